wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/cpu_pkg.sv | 6 +
 rtl/wb_fwd_cmp.sv | 16 +
 rtl/wb_arbiter.sv | 75 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared writeback-arbiter types and constants
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int STARVE_MAX_DEF = 3;
  typedef enum logic {LD_PRI = 1'b0, EX_PRI = 1'b1} pri_t;
endpackage

// File: rtl/wb_fwd_cmp.sv
// wb_fwd_cmp: matches one decode read address against the pending register-file write
module wb_fwd_cmp
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   w_data,
  input  logic [REG_AW-1:0] rs,
  output logic              hit,
  output logic [XLEN-1:0]   data
);
  assign hit  = reg_write && rd != '0 && rd == rs;
  assign data = hit ? w_data : '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: execute/load arbitration for the single register-file write port with anti-starvation and bypass
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int XLEN       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  output logic              ex_ready,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  output logic              reg_write,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   w_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  pri_t              state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              ex_g, ld_g;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  // grant selection, starvation count and priority-state update; nothing is granted during reset
  always_comb begin
    ex_g     = rst_n && ex_valid && (!ld_valid || state == EX_PRI);
    ld_g     = rst_n && ld_valid && (!ex_valid || state == LD_PRI);
    sel_rd   = ex_g ? ex_rd : ld_rd;
    sel_data = ex_g ? ex_data : ld_data;
    cnt_nx   = (ex_valid && ld_g) ? ((cnt == CW'(STARVE_MAX)) ? cnt : cnt + 1'b1) : '0;
    state_nx = ex_g ? LD_PRI : (state == LD_PRI && cnt_nx == CW'(STARVE_MAX)) ? EX_PRI : state;
  end
  assign ex_ready = ex_g;
  assign ld_ready = ld_g;
  // priority state and starvation counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LD_PRI;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // register the granted write one cycle later; x0 writes update rd/w_data but never assert reg_write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      rd        <= '0;
      w_data    <= '0;
    end else begin
      reg_write <= (ex_g || ld_g) && sel_rd != '0;
      if (ex_g || ld_g) begin
        rd     <= sel_rd;
        w_data <= sel_data;
      end
    end
  end
  wb_fwd_cmp #(.XLEN(XLEN)) u_fwd1 (
    .reg_write(reg_write), .rd(rd), .w_data(w_data), .rs(rs1), .hit(fwd1_hit), .data(fwd1_data)
  );
  wb_fwd_cmp #(.XLEN(XLEN)) u_fwd2 (
    .reg_write(reg_write), .rd(rd), .w_data(w_data), .rs(rs2), .hit(fwd2_hit), .data(fwd2_data)
  );
endmodule
